cpu_data_mem_responder: RTL
===========================

# cpu_data_mem_responder

Memory-side responder for the CPU data port: it accepts load/store requests issued by the multi-cycle CPU (Address, MemRead, MemWrite, Write_data, Write_strb) and serves them from an internal word array. The request/response handshake has programmable wait states on both the request-accept path and the read-response path, so the CPU's stall logic can be exercised against a non-ideal memory. It sits between the CPU top level and the simulation/FPGA memory wrapper, replacing the zero-latency data memory.

## Interface
- ADDR_WIDTH, 10, word-index bits; array depth = 2^ADDR_WIDTH words of 32 bits
- REQ_LATENCY, 2, wait cycles from the first IDLE cycle that sees a request to Mem_Req_Ready (range 0..255)
- RESP_LATENCY, 1, cycles from the read handshake to the first Read_data_Valid cycle, minus one (range 0..255)
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- Address  in  32  byte address; [1:0] ignored, word index = Address[ADDR_WIDTH+1:2]
- MemRead  in  1  read request, held by CPU until handshake
- MemWrite  in  1  write request, held by CPU until handshake
- Write_data  in  32  store data, byte lanes pre-aligned by CPU
- Write_strb  in  4  byte enables, bit i writes Write_data[8i+7:8i]
- Mem_Req_Ready  out  1  request accepted this cycle when high together with MemRead|MemWrite
- Read_data  out  32  load data
- Read_data_Valid  out  1  Read_data valid
- Read_data_Ready  in  1  CPU accepts read data

## Operation
- States: IDLE, WAIT, RD_WAIT, RESP; 8-bit down-counter cnt.
- IDLE: if MemRead|MemWrite → WAIT, cnt ← REQ_LATENCY.
- WAIT: request dropped → IDLE (no access, counter discarded). cnt≠0 → cnt−1. cnt==0 → Mem_Req_Ready=1 (combinational from state and cnt); handshake occurs this cycle.
- Write handshake (MemWrite=1): lanes with Write_strb[i]=1 updated at the clock edge ending the cycle; other lanes unchanged → IDLE. Write_strb=0000 is a legal no-op.
- Read handshake (MemRead=1, MemWrite=0): addressed word captured into the Read_data register at the same edge; → RESP if RESP_LATENCY==0, else → RD_WAIT, cnt ← RESP_LATENCY−1.
- MemRead and MemWrite both high: treated as a write; no read response.
- RD_WAIT: cnt≠0 → cnt−1; cnt==0 → RESP.
- RESP: Read_data_Valid=1; Read_data stable. Read_data_Ready=1 → IDLE. Requests are ignored in RD_WAIT and RESP.
- Read_data keeps its last value after the response completes; it changes only on a read handshake or reset.
- Address aliasing: bits above ADDR_WIDTH+1 are ignored (wrap-around); no error is flagged.
- Array contents are not reset; simulation initial value is 0.

## Timing
- Reset (rst=0, any state, asynchronous): state IDLE, cnt=0, Mem_Req_Ready=0, Read_data_Valid=0, Read_data=0. The array is untouched; a write whose handshake edge coincides with reset assertion is not committed.
- A request first seen in IDLE at cycle T gives Mem_Req_Ready high exactly in cycle T+1+REQ_LATENCY, for one cycle.
- A read handshake at cycle H gives Read_data_Valid first high in cycle H+1+RESP_LATENCY; it stays high until the cycle Read_data_Ready=1 (inclusive).
- The earliest next request is seen in IDLE one cycle after the write handshake or the response handshake. Back-to-back accesses therefore cost 2+REQ_LATENCY cycles per write.
- Read-after-write to the same word returns the new data (the write commits before the next read's handshake).
- Mem_Req_Ready and Read_data_Valid are never high in the same cycle.

## Test plan
- Reset: drive rst=0 while in RESP with Read_data=0x12345678 → Read_data_Valid, Mem_Req_Ready and Read_data go to 0 immediately, without a clock edge; after release, IDLE with no spurious Ready.
- Word store/load, REQ_LATENCY=2, RESP_LATENCY=1: store 0xDEADBEEF to 0x10 with strb 1111, request first seen in IDLE at T → Ready only at T+3. Load 0x10 with handshake at H → Valid at H+2, Read_data=0xDEADBEEF.
- Byte strobes: store 0x11223344 with strb 0101 over 0xDEADBEEF at 0x10 → load returns 0xDE22BE44; strb 0000 → word unchanged.
- Backpressure: hold Read_data_Ready=0 for 5 cycles in RESP → Valid and Read_data stay constant; Ready=1 → Valid low next cycle, state IDLE.
- Withdrawal and conflict: drop MemWrite during WAIT → no Ready and memory unchanged. MemRead=MemWrite=1 → write committed, Read_data_Valid never asserted.
- Aliasing and zero latency, REQ_LATENCY=0, RESP_LATENCY=0, ADDR_WIDTH=10: load 0x1013 → Ready at T+1, Valid at H+1, data equal to the word at 0x10.

Source files
------------

// File: rtl/cpu_data_mem_responder.sv
// CPU data-port memory responder with programmable request/response wait states.
// Ready after REQ_LATENCY+1 cycles in WAIT; read data held in RESP until Read_data_Ready.
module cpu_data_mem_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int REQ_LATENCY  = 2,
  parameter int RESP_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [7:0] REQ_CNT  = 8'(REQ_LATENCY);
  localparam logic [7:0] RESP_CNT = 8'(RESP_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RD_WAIT,
    S_RESP
  } state_t;

  state_t                  state, state_n;
  logic [7:0]              cnt, cnt_n;
  logic                    req;
  logic                    mem_we;
  logic                    rd_cap;
  logic [ADDR_WIDTH-1:0]   widx;
  logic [31:0]             mem [DEPTH];
  logic                    unused_addr_bits;

  assign req              = MemRead | MemWrite;
  assign widx             = Address[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

  assign Mem_Req_Ready   = (state == S_WAIT) && (cnt == 8'd0);
  assign Read_data_Valid = (state == S_RESP);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mem_we  = 1'b0;
    rd_cap  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_n = S_WAIT;
          cnt_n   = REQ_CNT;
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_n = S_IDLE;
        end else if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else if (MemWrite) begin
          // A simultaneous read+write is served as a write only.
          mem_we  = 1'b1;
          state_n = S_IDLE;
        end else begin
          rd_cap = 1'b1;
          if (RESP_LATENCY == 0) begin
            state_n = S_RESP;
          end else begin
            state_n = S_RD_WAIT;
            cnt_n   = RESP_CNT;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt != 8'd0) cnt_n = cnt - 8'd1;
        else             state_n = S_RESP;
      end
      S_RESP: begin
        if (Read_data_Ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      Read_data <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (rd_cap) Read_data <= mem[widx];
    end
  end

  // Array is not reset; a write landing on the reset-assert edge is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && rst) begin
      for (int i = 0; i < 4; i++) begin
        if (Write_strb[i]) mem[widx][8*i +: 8] <= Write_data[8*i +: 8];
      end
    end
  end

endmodule
